// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the datapath and pipeline_ctrl.
// PIPE_PERF_CNT_EN adds the stall/flush performance counter outputs.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

interface pipeline_ctrl_if;
  logic [`INSTRUCTION_WIDTH-1:0] instruction_ID;
  logic [`INSTRUCTION_WIDTH-1:0] instruction_EX;
  logic                          branch_taken_EX;
  logic                          fetch_ready;
  logic                          mem_req_MEM;
  logic                          mem_ready;
  logic                          pc_write;
  logic                          load_IF_ID;
  logic                          load_ID_EX;
  logic                          load_EX_MEM;
  logic                          flush_IF_ID;
  logic                          flush_ID_EX;
  logic                          mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]                   stall_cycles;
  logic [31:0]                   flush_count;
`endif

  // Datapath side: supplies stage state, consumes bank controls.
  modport master (
    output instruction_ID, instruction_EX, branch_taken_EX, fetch_ready, mem_req_MEM, mem_ready,
    input  pc_write, load_IF_ID, load_ID_EX, load_EX_MEM, flush_IF_ID, flush_ID_EX, mem_timeout
`ifdef PIPE_PERF_CNT_EN
    , input stall_cycles, flush_count
`endif
  );

  // Controller side.
  modport slave (
    input  instruction_ID, instruction_EX, branch_taken_EX, fetch_ready, mem_req_MEM, mem_ready,
    output pc_write, load_IF_ID, load_ID_EX, load_EX_MEM, flush_IF_ID, flush_ID_EX, mem_timeout
`ifdef PIPE_PERF_CNT_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller driving IF-ID, ID-EX, EX-MEM bank load/flush and PC enable.
// Optional PIPE_PERF_CNT_EN: stall_cycles / flush_count performance counters.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module pipeline_ctrl #(
  parameter logic [5:0]  OPCODE_LW = 6'b100011,
  parameter int unsigned REG_W     = 5,
  parameter int unsigned MAX_WAIT  = 255
) (
  input logic             clk,
  input logic             reset_n,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StRun, StLuStall, StFetchWait, StMemWait} state_e;

  localparam logic [7:0] MaxWaitCnt = 8'(MAX_WAIT);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic       pc_write_c, load_if_id_c, load_id_ex_c, load_ex_mem_c;
  logic       flush_if_id_c, flush_id_ex_c, branch_flush_c;

  logic [5:0]       op_ex;
  logic [REG_W-1:0] rt_ex, rs_id, rt_id;
  logic             load_use, mem_stall;

  assign op_ex = bus.instruction_EX[31:26];
  assign rt_ex = bus.instruction_EX[16 +: REG_W];
  assign rs_id = bus.instruction_ID[21 +: REG_W];
  assign rt_id = bus.instruction_ID[16 +: REG_W];

  logic unused_instr;
  assign unused_instr = ^{bus.instruction_ID[31:26], bus.instruction_ID[15:0],
                          bus.instruction_EX[25:21], bus.instruction_EX[15:0]};

  // $zero can never be a real producer, so a load to it is never a hazard.
  assign load_use  = (op_ex == OPCODE_LW) && (rt_ex != '0) &&
                     ((rt_ex == rs_id) || (rt_ex == rt_id));
  assign mem_stall = bus.mem_req_MEM & ~bus.mem_ready;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = 1'b0;
    pc_write_c     = 1'b0;
    load_if_id_c   = 1'b0;
    load_id_ex_c   = 1'b0;
    load_ex_mem_c  = 1'b0;
    flush_if_id_c  = 1'b0;
    flush_id_ex_c  = 1'b0;
    branch_flush_c = 1'b0;

    if (state_q == StMemWait && !bus.mem_ready) begin
      // Pipeline frozen while the data access is outstanding.
      if (wait_cnt_q == MaxWaitCnt) begin
        mem_timeout_d = 1'b1;
        state_d       = StRun;
        wait_cnt_d    = '0;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end else if (state_q != StMemWait && mem_stall) begin
      state_d    = StMemWait;
      wait_cnt_d = 8'd1;
    end else begin
      wait_cnt_d = '0;
      if (bus.branch_taken_EX) begin
        pc_write_c     = 1'b1;
        flush_if_id_c  = 1'b1;
        flush_id_ex_c  = 1'b1;
        load_ex_mem_c  = 1'b1;
        branch_flush_c = 1'b1;
        state_d        = StRun;
      end else if (!bus.fetch_ready) begin
        flush_if_id_c = 1'b1;
        load_id_ex_c  = 1'b1;
        load_ex_mem_c = 1'b1;
        state_d       = StFetchWait;
      end else if (state_q != StLuStall && load_use) begin
        flush_id_ex_c = 1'b1;
        load_ex_mem_c = 1'b1;
        state_d       = StLuStall;
      end else begin
        pc_write_c    = 1'b1;
        load_if_id_c  = 1'b1;
        load_id_ex_c  = 1'b1;
        load_ex_mem_c = 1'b1;
        state_d       = StRun;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Reset forces every bank control low in the same cycle.
  assign bus.pc_write    = reset_n & pc_write_c;
  assign bus.load_IF_ID  = reset_n & load_if_id_c;
  assign bus.load_ID_EX  = reset_n & load_id_ex_c;
  assign bus.load_EX_MEM = reset_n & load_ex_mem_c;
  assign bus.flush_IF_ID = reset_n & flush_if_id_c;
  assign bus.flush_ID_EX = reset_n & flush_id_ex_c;
  assign bus.mem_timeout = mem_timeout_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_write_c) stall_cycles_d = stall_cycles_q + 32'd1;
    if (branch_flush_c) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a rule-level reference model.
// Build with +define+PIPE_PERF_CNT_EN to also check the performance counters.
`timescale 1ns/1ps

module tb_pipeline_ctrl;

  localparam int MaxWait = 4;
  localparam logic [5:0] OpLw = 6'b100011;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(
    .OPCODE_LW (OpLw),
    .REG_W     (5),
    .MAX_WAIT  (MaxWait)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, kept as "what is the pipeline waiting for".
  bit          m_mem_waiting;
  int          m_waited;
  bit          m_bubble_done;
  bit          m_tmo;
  int unsigned m_stalls;
  int unsigned m_flushes;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit hazard(input logic [31:0] iid, input logic [31:0] iex);
    logic [4:0] dst;
    dst = iex[20:16];
    return (iex[31:26] == OpLw) && (dst != 5'd0) && (dst == iid[25:21] || dst == iid[20:16]);
  endfunction

  // {pc_write, load_IF_ID, load_ID_EX, load_EX_MEM, flush_IF_ID, flush_ID_EX}
  function automatic logic [5:0] model_ctrl(input logic rst, input logic [31:0] iid,
                                            input logic [31:0] iex, input logic br,
                                            input logic fr, input logic mq, input logic mr);
    if (!rst) return 6'b000000;
    if (m_mem_waiting && !mr) return 6'b000000;
    if (!m_mem_waiting && mq && !mr) return 6'b000000;
    if (br) return 6'b100111;
    if (!fr) return 6'b001110;
    if (!m_bubble_done && hazard(iid, iex)) return 6'b000101;
    return 6'b111100;
  endfunction

  task automatic model_update(input logic rst, input logic [31:0] iid, input logic [31:0] iex,
                              input logic br, input logic fr, input logic mq, input logic mr,
                              input logic [5:0] exp);
    bit was_bubble;
    if (!rst) begin
      m_mem_waiting = 0; m_waited = 0; m_bubble_done = 0; m_tmo = 0;
      m_stalls = 0; m_flushes = 0;
      return;
    end
    was_bubble = m_bubble_done;
    m_tmo = 0;
    m_bubble_done = 0;
    if (exp[5] == 1'b0) m_stalls++;
    if (m_mem_waiting && !mr) begin
      if (m_waited == MaxWait) begin
        m_tmo = 1; m_mem_waiting = 0; m_waited = 0;
      end else begin
        m_waited++;
      end
    end else if (!m_mem_waiting && mq && !mr) begin
      m_mem_waiting = 1; m_waited = 1;
    end else begin
      m_mem_waiting = 0; m_waited = 0;
      if (br) m_flushes++;
      m_bubble_done = !br && fr && !was_bubble && hazard(iid, iex);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic [31:0] iid,
                      input logic [31:0] iex, input logic br, input logic fr,
                      input logic mq, input logic mr);
    logic [5:0] exp;
    @(posedge clk);
    #2;
    reset_n             = rst;
    bus.instruction_ID  = iid;
    bus.instruction_EX  = iex;
    bus.branch_taken_EX = br;
    bus.fetch_ready     = fr;
    bus.mem_req_MEM     = mq;
    bus.mem_ready       = mr;
    #1;
    exp = model_ctrl(rst, iid, iex, br, fr, mq, mr);
    check_eq({tag, "_ctrl"}, 32'({bus.pc_write, bus.load_IF_ID, bus.load_ID_EX, bus.load_EX_MEM,
                                  bus.flush_IF_ID, bus.flush_ID_EX}), 32'(exp));
    check_eq({tag, "_tmo"}, 32'(bus.mem_timeout), 32'(rst ? m_tmo : 1'b0));
`ifdef PIPE_PERF_CNT_EN
    check_eq({tag, "_stalls"}, bus.stall_cycles, rst ? m_stalls : 32'd0);
    check_eq({tag, "_flushes"}, bus.flush_count, rst ? m_flushes : 32'd0);
`endif
    model_update(rst, iid, iex, br, fr, mq, mr, exp);
  endtask

  function automatic logic [31:0] rand_instr(input bit lw_bias);
    logic [5:0] op;
    op = (lw_bias && $urandom_range(0, 1) == 0) ? OpLw : 6'($urandom);
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
  endfunction

  // add $t1, $t0, $t2 reads $t0 (reg 8); lw $t0 / lw $zero
  localparam logic [31:0] AddUsesT0 = {6'd0, 5'd8, 5'd10, 5'd9, 11'h020};
  localparam logic [31:0] LwT0      = {OpLw, 5'd29, 5'd8, 16'h0004};
  localparam logic [31:0] LwZero    = {OpLw, 5'd29, 5'd0, 16'h0004};
  localparam logic [31:0] AddZero   = {6'd0, 5'd0, 5'd0, 5'd9, 11'h020};
  localparam logic [31:0] Nop       = 32'd0;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    bus.instruction_ID = '0; bus.instruction_EX = '0; bus.branch_taken_EX = 1'b0;
    bus.fetch_ready = 1'b1; bus.mem_req_MEM = 1'b0; bus.mem_ready = 1'b0;
    model_update(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

    step("rst_hold", 0, Nop, Nop, 0, 1, 0, 0);
    step("rst_rel",  1, Nop, Nop, 0, 1, 0, 0);
    check_eq("rel_pc_write", 32'(bus.pc_write), 32'd1);
    step("run",      1, Nop, Nop, 0, 1, 0, 0);

    // Load-use: one bubble then normal even with instructions held.
    step("lu",       1, AddUsesT0, LwT0, 0, 1, 0, 0);
    check_eq("lu_flush_id_ex", 32'(bus.flush_ID_EX), 32'd1);
    step("lu_after", 1, AddUsesT0, LwT0, 0, 1, 0, 0);
    check_eq("lu_after_pc", 32'(bus.pc_write), 32'd1);
    step("lw_zero",  1, AddZero, LwZero, 0, 1, 0, 0);
    check_eq("lw_zero_pc", 32'(bus.pc_write), 32'd1);

    // Branch overrides load-use.
    step("br_lu",    1, AddUsesT0, LwT0, 1, 1, 0, 0);
    check_eq("br_flush_if_id", 32'(bus.flush_IF_ID), 32'd1);
    step("br_after", 1, Nop, Nop, 0, 1, 0, 0);

    // Three not-ready cycles, then resume.
    for (int i = 0; i < 3; i++) step("mem3", 1, Nop, Nop, 0, 1, 1, 0);
    step("mem3_done", 1, Nop, Nop, 0, 1, 1, 1);
    check_eq("mem3_resume", 32'(bus.load_IF_ID), 32'd1);

    // Never ready: pulse after the wait budget.
    for (int i = 0; i < MaxWait + 1; i++) step("mem_to", 1, Nop, Nop, 0, 1, 1, 0);
    step("mem_to_pulse", 1, Nop, Nop, 0, 1, 0, 0);
    check_eq("timeout_pulse", 32'(bus.mem_timeout), 32'd1);
    step("mem_to_clear", 1, Nop, Nop, 0, 1, 0, 0);

    // Reset in the middle of a memory wait: no pulse afterwards.
    for (int i = 0; i < 3; i++) step("mem_rst", 1, Nop, Nop, 0, 1, 1, 0);
    step("mem_rst_lo", 0, Nop, Nop, 0, 1, 1, 0);
    for (int i = 0; i < MaxWait + 2; i++) step("mem_rst_hi", 1, Nop, Nop, 0, 1, 0, 0);

    // Two fetch-wait cycles.
    step("fw", 1, Nop, Nop, 0, 0, 0, 0);
    step("fw", 1, Nop, Nop, 0, 0, 0, 0);
    step("fw_done", 1, Nop, Nop, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic rst;
      rst = ($urandom_range(0, 199) != 0);
      step("rand", rst, rand_instr(1'b0), rand_instr(1'b1),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
